alu_exec_unit: RTL

Execute stage placed directly downstream of the register file's two buffered read ports. Takes both operand buffers plus a 3-bit opcode on a start pulse. Produces a registered result and status flags with a one-cycle done pulse; the result feeds the register file's write-data input. Single-cycle logic and arithmetic ops; multi-cycle iterative shift-add multiply.

---
 rtl/alu_exec_unit.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execute stage behind the register file's buffered read ports.
// Logic, add/sub and shift ops finish in one cycle. Unsigned multiply is an
// iterative shift-add that takes WORD_SIZE cycles. The result and the flags are
// registered, and each completion raises a one-cycle done pulse.
module alu_exec_unit #(
    parameter int WORD_SIZE = 16,
    parameter int SH_W      = $clog2(WORD_SIZE)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [2:0]           op,
    input  logic [WORD_SIZE-1:0] a,
    input  logic [WORD_SIZE-1:0] b,
    output logic [WORD_SIZE-1:0] result,
    output logic                 done,
    output logic                 busy,
    output logic                 zero,
    output logic                 carry,
    output logic                 negative
);

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SHL = 3'b101,
        OP_SHR = 3'b110,
        OP_MUL = 3'b111
    } op_t;

    typedef enum logic {
        IDLE,
        MUL
    } state_t;

    localparam int ACC_W = 2 * WORD_SIZE;

    state_t                 state, state_next;
    logic [ACC_W-1:0]       acc, acc_next;
    logic [ACC_W-1:0]       mcand, mcand_next;
    logic [WORD_SIZE-1:0]   mplier, mplier_next;
    logic [SH_W-1:0]        count, count_next;
    logic [WORD_SIZE-1:0]   result_next;
    logic                   done_next, busy_next;
    logic                   zero_next, carry_next, negative_next;

    logic [SH_W-1:0]        sh;
    logic [WORD_SIZE:0]     wide;
    logic [WORD_SIZE-1:0]   alu_res;
    logic                   alu_carry;
    logic [ACC_W-1:0]       acc_sum;

    assign sh      = b[SH_W-1:0];
    assign acc_sum = acc + (mplier[0] ? mcand : '0);

    // Single-cycle datapath. The extra bit of 'wide' is the carry, borrow or shifted-out bit.
    always_comb begin
        // NOTE: every variable written in this block gets a default first, so no path can infer a latch.
        wide      = '0;
        alu_res   = '0;
        alu_carry = 1'b0;
        case (op_t'(op))
            OP_ADD: begin
                wide      = {1'b0, a} + {1'b0, b};
                alu_res   = wide[WORD_SIZE-1:0];
                alu_carry = wide[WORD_SIZE];
            end
            OP_SUB: begin
                // Bit WORD_SIZE of the zero-extended difference is set exactly when a < b.
                wide      = {1'b0, a} - {1'b0, b};
                alu_res   = wide[WORD_SIZE-1:0];
                alu_carry = wide[WORD_SIZE];
            end
            OP_AND: alu_res = a & b;
            OP_OR:  alu_res = a | b;
            OP_XOR: alu_res = a ^ b;
            OP_SHL: begin
                // Bit WORD_SIZE receives a[WORD_SIZE-sh]. When sh==0 it stays 0.
                wide      = {1'b0, a} << sh;
                alu_res   = wide[WORD_SIZE-1:0];
                alu_carry = wide[WORD_SIZE];
            end
            OP_SHR: begin
                // Bit 0 receives a[sh-1]. When sh==0 it stays 0.
                wide      = {a, 1'b0} >> sh;
                alu_res   = wide[WORD_SIZE:1];
                alu_carry = wide[0];
            end
            default: ;
        endcase
    end

    // Next-state and next-output logic for the IDLE/MUL controller.
    always_comb begin
        state_next    = state;
        acc_next      = acc;
        mcand_next    = mcand;
        mplier_next   = mplier;
        count_next    = count;
        result_next   = result;
        zero_next     = zero;
        carry_next    = carry;
        negative_next = negative;
        busy_next     = busy;
        done_next     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (op_t'(op) == OP_MUL) begin
                        acc_next    = '0;
                        mcand_next  = {{WORD_SIZE{1'b0}}, a};
                        mplier_next = b;
                        count_next  = '0;
                        busy_next   = 1'b1;
                        state_next  = MUL;
                    end else begin
                        result_next   = alu_res;
                        carry_next    = alu_carry;
                        zero_next     = (alu_res == '0);
                        negative_next = alu_res[WORD_SIZE-1];
                        done_next     = 1'b1;
                    end
                end
            end
            MUL: begin
                acc_next    = acc_sum;
                mcand_next  = mcand << 1;
                mplier_next = mplier >> 1;
                count_next  = count + 1'b1;
                // This edge performs the last iteration, so the result is taken from acc_sum.
                if (count == SH_W'(WORD_SIZE - 1)) begin
                    result_next   = acc_sum[WORD_SIZE-1:0];
                    carry_next    = |acc_sum[ACC_W-1:WORD_SIZE];
                    zero_next     = (acc_sum[WORD_SIZE-1:0] == '0);
                    negative_next = acc_sum[WORD_SIZE-1];
                    done_next     = 1'b1;
                    busy_next     = 1'b0;
                    state_next    = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register. Reset overrides everything and drops any multiply in flight.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (rst) begin
            state    <= IDLE;
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            count    <= '0;
            result   <= '0;
            zero     <= 1'b0;
            carry    <= 1'b0;
            negative <= 1'b0;
            done     <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_next;
            acc      <= acc_next;
            mcand    <= mcand_next;
            mplier   <= mplier_next;
            count    <= count_next;
            result   <= result_next;
            zero     <= zero_next;
            carry    <= carry_next;
            negative <= negative_next;
            done     <= done_next;
            busy     <= busy_next;
        end
    end

endmodule
